// File: rtl/x_uart_pkg.sv
// ---------------------------------------------------------------------------
// x_uart_pkg
// Shared definitions for the UART blocks of this codebase.
//   - sm_uart_tx_t : transmitter frame states. PAR is always part of the
//                    encoding, even when parity is compiled out of the TX.
//   - timer_top()  : bit period in clock cycles (integer division).
//   - frame constants: data bit count, idle and start line levels.
// ---------------------------------------------------------------------------
package x_uart_pkg;

    localparam int unsigned UART_DATA_BITS   = 8;
    localparam logic        UART_IDLE_LEVEL  = 1'b1;
    localparam logic        UART_START_LEVEL = 1'b0;

    typedef enum logic [3:0] {
        IDLE,
        START,
        D0, D1, D2, D3, D4, D5, D6, D7,
        PAR,
        STOP1,
        STOP2
    } sm_uart_tx_t;

    // Cycles per bit. TX and RX both derive their bit period from this so a
    // loopback pair always agrees.
    function automatic int unsigned timer_top(input int unsigned clk_hz,
                                              input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/x_uart_baud_tick.sv
// ---------------------------------------------------------------------------
// x_uart_baud_tick
// Free-running bit timer. Counts 0..p_top-1 while enabled and pulses o_tick
// for one cycle at count p_top-1, wrapping to 0 on the same edge. Held at 0
// whenever i_en is low so the first bit after enabling is a full period.
// Ports:
//   i_clk  : clock
//   i_rst  : synchronous active-high reset
//   i_en   : count enable; low clears the counter
//   o_tick : one-cycle pulse on the last cycle of each bit period
// ---------------------------------------------------------------------------
module x_uart_baud_tick #(
    parameter int unsigned p_top = 104
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int unsigned W = $clog2(p_top + 1);
    localparam logic [W-1:0] TOP_M1 = W'(p_top - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        o_tick  = 1'b0;
        if (!i_en) begin
            count_d = '0;
        end else if (count_q == TOP_M1) begin
            count_d = '0;
            o_tick  = 1'b1;
        end else begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/x_uart_tx.sv
// ---------------------------------------------------------------------------
// x_uart_tx
// UART transmitter: 1 start bit, 8 data bits LSB first, optional even parity,
// p_stop_bits stop bits. Every non-IDLE state lasts p_clk_hz/p_baud cycles.
// Build option: define X_UART_TX_PARITY_EN to insert the even-parity bit
// after D7 (8E1/8E2); undefined gives 8N1/8N2 with no parity logic.
// Handshake: a byte is accepted on a rising edge where i_valid & o_ready.
//   o_ready depends on state only, never on i_valid; i_data is only looked at
//   on the accept edge, so it may change freely at any other time.
// Ports:
//   i_clk   : clock
//   i_rst   : synchronous active-high reset; aborts any frame in flight
//   i_valid : producer offers i_data
//   i_data  : byte to send, latched on accept
//   o_ready : block is IDLE and can take a byte
//   o_busy  : frame in progress
//   o_tx    : serial line, idle high, straight from a flop
// ---------------------------------------------------------------------------
module x_uart_tx
    import x_uart_pkg::*;
#(
    parameter int unsigned p_clk_hz    = 12000000,
    parameter int unsigned p_baud      = 115200,
    parameter int unsigned p_stop_bits = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_tx
);

    localparam int unsigned TOP = timer_top(p_clk_hz, p_baud);

    sm_uart_tx_t state_q;
    sm_uart_tx_t state_d;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [UART_DATA_BITS-1:0] shift_d;
    logic tx_q;
    logic tx_d;
    logic bit_tick;
    logic accept;

`ifdef X_UART_TX_PARITY_EN
    logic par_q;
    logic par_d;
`endif

    x_uart_baud_tick #(
        .p_top(TOP)
    ) u_baud_tick (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (state_q != IDLE),
        .o_tick(bit_tick)
    );

    assign o_ready = (state_q == IDLE);
    assign o_busy  = ~o_ready;
    assign o_tx    = tx_q;
    assign accept  = i_valid & o_ready;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
`ifdef X_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q == IDLE) begin
            if (accept) begin
                state_d = START;
                shift_d = i_data;
`ifdef X_UART_TX_PARITY_EN
                par_d   = ^i_data;
`endif
            end
        end else if (bit_tick) begin
            case (state_q)
                START: state_d = D0;
                D0, D1, D2, D3, D4, D5, D6: begin
                    // Data states are consecutive in the encoding.
                    state_d = sm_uart_tx_t'(state_q + 4'd1);
                    shift_d = shift_q >> 1;
                end
                D7: begin
                    shift_d = shift_q >> 1;
`ifdef X_UART_TX_PARITY_EN
                    state_d = PAR;
`else
                    state_d = STOP1;
`endif
                end
                PAR:     state_d = STOP1;
                STOP1:   state_d = (p_stop_bits == 2) ? STOP2 : IDLE;
                STOP2:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // The line level is decoded from the next state and registered, so o_tx
    // changes on the same edge as the state and never glitches.
    always_comb begin
        tx_d = UART_IDLE_LEVEL;
        case (state_d)
            START:                          tx_d = UART_START_LEVEL;
            D0, D1, D2, D3, D4, D5, D6, D7: tx_d = shift_d[0];
`ifdef X_UART_TX_PARITY_EN
            PAR:                            tx_d = par_d;
`endif
            default:                        tx_d = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            tx_q    <= UART_IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

`ifdef X_UART_TX_PARITY_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule
